// File: rtl/keccak_pkg.sv
// Shared Keccak rho-stage definitions: lane geometry, FSM states and the rho offset table.
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

  typedef logic [4:0] lane_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_ROT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [5:0] RHO_OFFSET [0:NUM_LANES-1] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  // A shift by the full width yields zero, so off=0 falls out as identity.
  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v,
                                             input logic [5:0] off);
    return (v << off) | (v >> (7'd64 - {1'b0, off}));
  endfunction

endpackage

// File: rtl/rho_offset_rom.sv
// Combinational lane index -> rho rotation offset lookup.
module rho_offset_rom
  import keccak_pkg::*;
(
  input  lane_idx_t   i_idx,
  output logic [5:0]  o_off
);

  always_comb begin
    o_off = '0;
    if (int'(i_idx) < NUM_LANES) o_off = RHO_OFFSET[i_idx];
  end

endmodule

// File: rtl/rho_lane_rotator.sv
// Lane-serial Keccak rho stage: read lane, rotate by its offset, write it back out.
// RHO_BARREL_EN selects a single-cycle barrel rotate; otherwise rotate 1 bit per cycle.
module rho_lane_rotator
  import keccak_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_rd_en,
  output logic [4:0]        o_rd_addr,
  input  logic [LANE_W-1:0] i_rd_data,
  output logic              o_wr_en,
  output logic [4:0]        o_wr_addr,
  output logic [LANE_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  state_t            r_state, w_next;
  lane_idx_t         r_n;
  logic [LANE_W-1:0] r_lane;
  logic              r_done;
  logic [5:0]        w_off;
  logic              w_last;

`ifndef RHO_BARREL_EN
  logic [5:0]        r_cnt;
`endif

  rho_offset_rom u_rom (
    .i_idx (r_n),
    .o_off (w_off)
  );

  assign w_last = (int'(r_n) == NUM_LANES - 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_RD;
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_ROT;
`ifdef RHO_BARREL_EN
      S_ROT:  w_next = S_WR;
`else
      // off=0 still spends one ROT cycle, doing nothing
      S_ROT:  if (w_off == 6'd0 || r_cnt == w_off - 6'd1) w_next = S_WR;
`endif
      S_WR:   w_next = w_last ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n    <= '0;
      r_lane <= '0;
      r_done <= 1'b0;
`ifndef RHO_BARREL_EN
      r_cnt  <= '0;
`endif
    end else begin
      // done is registered off DONE so it pulses in the cycle IDLE is re-entered
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_CAP: begin
          r_lane <= i_rd_data;
`ifndef RHO_BARREL_EN
          r_cnt  <= '0;
`endif
        end
        S_ROT: begin
`ifdef RHO_BARREL_EN
          r_lane <= rotl(r_lane, w_off);
`else
          if (w_off != 6'd0) begin
            r_lane <= {r_lane[LANE_W-2:0], r_lane[LANE_W-1]};
            r_cnt  <= r_cnt + 6'd1;
          end
`endif
        end
        S_WR:   if (!w_last) r_n <= r_n + 5'd1;
        S_DONE: r_n <= '0;
        default: ;
      endcase
    end
  end

  assign o_rd_en   = (r_state == S_RD);
  assign o_rd_addr = o_rd_en ? r_n : '0;
  assign o_wr_en   = (r_state == S_WR);
  assign o_wr_addr = o_wr_en ? r_n : '0;
  assign o_wr_data = o_wr_en ? r_lane : '0;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;

endmodule
